// File: rtl/uart_rx.sv
// UART receive engine: 2-FF input synchronizer, oversampled majority-vote bit recovery,
// optional even/odd parity, and a single-entry valid/ready output buffer with overrun flag.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sample_tick,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] MAJ_A    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MAJ_B    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MAJ_C    = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [BW-1:0]          bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0]   shreg, shreg_d;
  logic                   perr, perr_d;
  logic [1:0]             samp, samp_d;
  logic [1:0]             sync_q;
  logic                   rxs;
  logic                   maj;
  logic                   complete;
  logic                   stop_err;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_in};
  end

  assign rxs = sync_q[1];
  assign maj = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      samp    <= 2'b11;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      perr    <= perr_d;
      samp    <= samp_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    perr_d    = perr;
    samp_d    = samp;
    complete  = 1'b0;
    stop_err  = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (sample_tick) begin
      cnt_d = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (cnt == MAJ_A) samp_d[0] = rxs;
      if (cnt == MAJ_B) samp_d[1] = rxs;

      unique case (state)
        S_IDLE: begin
          cnt_d = '0;
          if (!rxs) begin
            // The detecting tick is tick 0 of the start bit.
            state_d = S_START;
            cnt_d   = CW'(1);
            perr_d  = 1'b0;
          end
        end
        S_START: begin
          if (cnt == MAJ_C && maj) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt == CNT_LAST) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
        S_DATA: begin
          if (cnt == MAJ_C) shreg_d = {maj, shreg[DATA_BITS-1:1]};
          if (cnt == CNT_LAST) begin
            if (bit_idx == BIT_LAST) state_d = parity_en ? S_PARITY : S_STOP;
            else                     bit_idx_d = bit_idx + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == MAJ_C)    perr_d  = (maj != (^shreg ^ parity_odd));
          if (cnt == CNT_LAST) state_d = S_STOP;
        end
        S_STOP: begin
          if (cnt == MAJ_C) begin
            complete = 1'b1;
            stop_err = ~maj;
            state_d  = maj ? S_IDLE : S_WAIT_HIGH;
            cnt_d    = '0;
          end
        end
        S_WAIT_HIGH: begin
          cnt_d = '0;
          if (rxs) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Single-entry output buffer: a completion while full is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          frame_err  <= stop_err;
          parity_err <= perr;
          rx_valid   <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner sequences,
// and randomized frames compared against a frame-level reference model.
`timescale 1ns/100ps
module tb_uart_rx;

  localparam int DB     = 8;
  localparam int OS     = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = OS * TDIV;

  logic          clk = 1'b0;
  logic          rst, en, sample_tick, parity_en, parity_odd, rx_in, rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, parity_err, rx_overrun, rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick),
    .parity_en(parity_en), .parity_odd(parity_odd), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err),
    .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample-tick strobe, one clk in every TDIV.
  int phase = 0;
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      phase       = (phase == TDIV - 1) ? 0 : phase + 1;
      sample_tick = (phase == 0);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } word_t;

  word_t got_q[$];
  int    tick_num  = 0;
  int    rise_cnt  = 0;
  int    rise_tick = 0;
  int    ovr_cnt   = 0;
  logic  prev_valid = 1'b0;

  // Monitor samples just before each rising edge, when inputs and outputs are settled.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rx_valid && !prev_valid) begin
        rise_cnt++;
        rise_tick = tick_num;
      end
      prev_valid = rx_valid;
      if (sample_tick) tick_num++;
      if (rx_overrun) ovr_cnt++;
      if (rx_valid && rx_ready && !rst)
        got_q.push_back('{data: rx_data, ferr: frame_err, perr: parity_err});
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (pe) send_bit(pb);
    send_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic expect_word(input string name, input logic [7:0] d, input logic fe, input logic pe);
    word_t w;
    int    n = 0;
    while (got_q.size() == 0 && n < 4 * BITCLK) begin
      @(negedge clk);
      n++;
    end
    check({name, " available"}, (got_q.size() != 0), 1);
    if (got_q.size() != 0) begin
      w = got_q.pop_front();
      check({name, " data"}, w.data, d);
      check({name, " frame_err"}, w.ferr, fe);
      check({name, " parity_err"}, w.perr, pe);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       odd;
    logic       pb;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    t0, r0, o0;
    logic [7:0] d;
    logic  pe, odd, pb, stop, exp_pb;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
    tbl[2] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[3] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
    tbl[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    rst = 1'b1; en = 1'b1; rx_in = 1'b1; rx_ready = 1'b1;
    parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {rx_data, rx_valid, frame_err, parity_err, rx_overrun, rx_busy}, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Basic frame and valid latency relative to the start-detect tick.
    r0 = rise_cnt;
    t0 = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (2) @(negedge clk);
        #2;
        while (!sample_tick) begin
          @(negedge clk);
          #2;
        end
        t0 = tick_num + 1;
      end
    join
    send_bit(1'b1);
    expect_word("basic A5", 8'hA5, 1'b0, 1'b0);
    check("basic valid pulses", rise_cnt - r0, 1);
    check("basic latency ticks", rise_tick - t0, 16 + 16 * DB + OS / 2 + 1);

    foreach (tbl[i]) begin
      parity_en  = tbl[i].pe;
      parity_odd = tbl[i].odd;
      send_frame(tbl[i].data, tbl[i].pe, tbl[i].pb, tbl[i].stop);
      send_bit(1'b1);
      expect_word($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_fe, tbl[i].exp_pe);
    end
    parity_en = 1'b0; parity_odd = 1'b0;

    // False start: two low ticks.
    r0 = rise_cnt;
    rx_in = 1'b0;
    repeat (2 * TDIV) @(negedge clk);
    check("false start busy", rx_busy, 1);
    rx_in = 1'b1;
    repeat (12 * TDIV) @(negedge clk);
    check("false start idle", rx_busy, 0);
    check("false start no valid", rise_cnt - r0, 0);

    // Held break yields one frame-error word, then normal reception.
    rx_in = 1'b0;
    repeat (3 * 10 * BITCLK) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    check("break word count", got_q.size(), 1);
    expect_word("break", 8'h00, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    expect_word("after break", 8'h5A, 1'b0, 1'b0);

    // Overrun with consumer stalled.
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    check("overrun pulses", ovr_cnt - o0, 1);
    check("overrun held valid", rx_valid, 1);
    check("overrun held data", rx_data, 8'h11);
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("overrun drained", rx_valid, 0);
    expect_word("overrun first", 8'h11, 1'b0, 1'b0);
    check("overrun no extra", got_q.size(), 0);

    // Async reset during data bit 3 of 0xFF.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx_in = 1'b1;
    repeat (BITCLK / 2) @(negedge clk);
    check("pre-reset busy", rx_busy, 1);
    rst = 1'b1;
    #1;
    check("mid-frame reset", {rx_data, rx_valid, frame_err, parity_err, rx_overrun, rx_busy}, 0);
    repeat (5) @(negedge clk);
    check("held reset", {rx_data, rx_valid, frame_err, parity_err, rx_overrun, rx_busy}, 0);
    rst = 1'b0;
    repeat (BITCLK) @(negedge clk);
    o0 = ovr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    expect_word("post-reset 1", 8'h3C, 1'b0, 1'b0);
    expect_word("post-reset 2", 8'h3C, 1'b0, 1'b0);
    check("post-reset no overrun", ovr_cnt - o0, 0);

    // Receiver disable mid-frame drops the frame silently.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("disable idle", rx_busy, 0);
    rx_in = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    en = 1'b1;
    repeat (BITCLK) @(negedge clk);
    check("disable no word", got_q.size(), 0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    expect_word("after disable", 8'hC3, 1'b0, 1'b0);

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 20; n++) begin
      d    = 8'($urandom_range(0, 255));
      pe   = 1'($urandom_range(0, 1));
      odd  = 1'($urandom_range(0, 1));
      pb   = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 4) != 0);
      parity_en  = pe;
      parity_odd = odd;
      send_frame(d, pe, pb, stop);
      send_bit(1'b1);
      exp_pb = (($countones(d) % 2) == 1) ^ odd;
      expect_word($sformatf("rand%0d", n), d, !stop, pe && (pb != exp_pb));
    end

    check("no stray words", got_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
